// File: rtl/shootout_score_ctl.sv
// Penalty shootout score controller: alternating kicks, early stop, optional sudden death.
// Sudden death is enabled by defining SHOOTOUT_SUDDEN_DEATH_EN.
module shootout_score_ctl #(
    parameter int ROUNDS  = 5,
    parameter int SD_MAX  = 7,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               match_start,
    input  logic               round_done,
    input  logic               is_scored,
    output logic               kick_side,
    output logic [SCORE_W-1:0] kick_idx,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_enemy,
    output logic               sudden_death,
    output logic               match_end,
    output logic               match_result,
    output logic               match_draw
);

    typedef enum logic [1:0] {IDLE, REGULAR, SUDDEN, DONE} state_t;

    localparam logic [SCORE_W-1:0] ONE  = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] RNDS = SCORE_W'(ROUNDS);
    localparam logic [SCORE_W-1:0] SDM  = SCORE_W'(SD_MAX);

    state_t             state, state_nx;
    logic [SCORE_W-1:0] kicks_p, kicks_e;
    logic [SCORE_W-1:0] sp_n, se_n, kp_n, ke_n;
    logic [SCORE_W:0]   wp, we, rem_p, rem_e;
    logic               kick, lead, level;

    assign kick = round_done && (state == REGULAR || state == SUDDEN);

    // Post-kick values; scores saturate defensively
    always_comb begin
        sp_n = score_player;
        se_n = score_enemy;
        kp_n = kicks_p;
        ke_n = kicks_e;
        if (!kick_side) begin
            kp_n = kicks_p + ONE;
            if (is_scored && !(&score_player)) sp_n = score_player + ONE;
        end else begin
            ke_n = kicks_e + ONE;
            if (is_scored && !(&score_enemy)) se_n = score_enemy + ONE;
        end
    end

    always_comb begin
        wp    = {1'b0, sp_n};
        we    = {1'b0, se_n};
        rem_p = {1'b0, RNDS} - {1'b0, kp_n};
        rem_e = {1'b0, RNDS} - {1'b0, ke_n};
        lead  = (wp > we + rem_e) || (we > wp + rem_p);
        level = (sp_n == se_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (match_start) begin
            state_nx = REGULAR;
        end else if (kick) begin
            case (state)
                REGULAR: begin
                    if (lead) begin
                        state_nx = DONE;
                    end else if (kick_side && ke_n == RNDS) begin
`ifdef SHOOTOUT_SUDDEN_DEATH_EN
                        state_nx = level ? SUDDEN : DONE;
`else
                        state_nx = DONE;
`endif
                    end
                end
                SUDDEN: begin
                    if (kick_side && (!level || ke_n == SDM)) state_nx = DONE;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_player <= '0;
            score_enemy  <= '0;
            kicks_p      <= '0;
            kicks_e      <= '0;
            kick_side    <= 1'b0;
        end else if (match_start) begin
            score_player <= '0;
            score_enemy  <= '0;
            kicks_p      <= '0;
            kicks_e      <= '0;
            kick_side    <= 1'b0;
        end else if (kick) begin
            score_player <= sp_n;
            score_enemy  <= se_n;
            kick_side    <= ~kick_side;
            // Per-side counters restart when the sudden-death phase begins
            if (state == REGULAR && state_nx == SUDDEN) begin
                kicks_p <= '0;
                kicks_e <= '0;
            end else begin
                kicks_p <= kp_n;
                kicks_e <= ke_n;
            end
        end
    end

    always_comb begin
        kick_idx     = kick_side ? kicks_e : kicks_p;
        match_end    = (state == DONE);
        match_result = match_end && (score_player > score_enemy);
        match_draw   = match_end && (score_player == score_enemy);
`ifdef SHOOTOUT_SUDDEN_DEATH_EN
        sudden_death = (state == SUDDEN);
`else
        sudden_death = 1'b0;
`endif
    end

endmodule
